router_input_channel: RTL and testbench

//  Receive side of the inter-router link. Accepts send_in/data_in from the

---
 rtl/router_input_channel.sv | 89 ++++++++
 tb/tb_router_input_channel.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/router_input_channel.sv
// Receive side of an inter-router link: two virtual-channel FIFOs. Polarity picks which
// VC takes flits from the link and which one serves the crossbar in each cycle.
module router_input_channel #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 2,
  parameter  int CNT_W  = 8,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              send_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              grant_in,
  output logic [OCC_W-1:0]  vc0_cnt,
  output logic [OCC_W-1:0]  vc1_cnt,
  output logic [CNT_W-1:0]  ovf_cnt
);

  // Index 0 is VC0 and index 1 is VC1 throughout.
  logic [DATA_W-1:0] r_mem  [2][DEPTH];
  logic [PTR_W-1:0]  r_wptr [2];
  logic [PTR_W-1:0]  r_rptr [2];
  logic [OCC_W-1:0]  r_cnt  [2];
  logic [CNT_W-1:0]  r_ovf;

  logic w_lvc;
  logic w_svc;
  logic w_ready;
  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_lvc   = ~polarity;
  assign w_svc   = polarity;
  assign w_ready = !reset && (r_cnt[w_lvc] < OCC_W'(DEPTH));
  assign w_req   = !reset && (r_cnt[w_svc] != '0);
  assign w_push  = send_in && w_ready;
  assign w_drop  = send_in && !w_ready && !reset;
  assign w_pop   = w_req && grant_in;

  // Storage has no reset; occupancy counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_lvc][r_wptr[w_lvc]] <= data_in;
    end
  end

  // Push and pop always address different VCs, so the two updates never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_wptr[w_lvc] <= r_wptr[w_lvc] + PTR_W'(1);
        r_cnt[w_lvc]  <= r_cnt[w_lvc] + OCC_W'(1);
      end
      if (w_pop) begin
        r_rptr[w_svc] <= r_rptr[w_svc] + PTR_W'(1);
        r_cnt[w_svc]  <= r_cnt[w_svc] - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= '0;
    end else if (w_drop && (r_ovf != '1)) begin
      r_ovf <= r_ovf + CNT_W'(1);
    end
  end

  assign ready_out = w_ready;
  assign req_out   = w_req;
  assign data_out  = w_req ? r_mem[w_svc][r_rptr[w_svc]] : '0;
  assign vc0_cnt   = r_cnt[0];
  assign vc1_cnt   = r_cnt[1];
  assign ovf_cnt   = r_ovf;

endmodule

// File: tb/tb_router_input_channel.sv
// Bench for router_input_channel: fixed vector table for the basic cases, then a
// queue-based reference model checked every cycle through streaming, reset and random traffic.
module tb_router_input_channel;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              reset;
  logic              polarity;
  logic              send_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_out;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              grant_in;
  logic [1:0]        vc0_cnt;
  logic [1:0]        vc1_cnt;
  logic [CNT_W-1:0]  ovf_cnt;

  router_input_channel #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .send_in   (send_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .req_out   (req_out),
    .data_out  (data_out),
    .grant_in  (grant_in),
    .vc0_cnt   (vc0_cnt),
    .vc1_cnt   (vc1_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  int                m_ovf = 0;

  typedef struct {
    logic              rst;
    logic              pol;
    logic              snd;
    logic [DATA_W-1:0] din;
    logic              gnt;
    logic              e_rdy;
    logic              e_req;
    logic [DATA_W-1:0] e_data;
    logic [1:0]        e_c0;
    logic [1:0]        e_c1;
    logic [CNT_W-1:0]  e_ovf;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic rst, pol, snd, input logic [DATA_W-1:0] din,
                              input logic gnt, e_rdy, e_req, input logic [DATA_W-1:0] e_data,
                              input logic [1:0] e_c0, e_c1, input logic [CNT_W-1:0] e_ovf);
    vec_t v;
    v.rst = rst; v.pol = pol; v.snd = snd; v.din = din; v.gnt = gnt;
    v.e_rdy = e_rdy; v.e_req = e_req; v.e_data = e_data;
    v.e_c0 = e_c0; v.e_c1 = e_c1; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle's inputs, check the DUT against the model, then advance the model
  // to the state the coming rising edge should produce.
  task automatic apply(input logic rst, pol, snd, input logic [DATA_W-1:0] din, input logic gnt);
    int                n0;
    int                n1;
    int                n_l;
    int                n_s;
    logic              m_rdy;
    logic              m_req;
    logic [DATA_W-1:0] m_data;
    @(negedge clk);
    reset    = rst;
    polarity = pol;
    send_in  = snd;
    data_in  = din;
    grant_in = gnt;
    #1;
    n0  = exp_q0.size();
    n1  = exp_q1.size();
    n_l = pol ? n0 : n1;
    n_s = pol ? n1 : n0;
    m_rdy  = !rst && (n_l < DEPTH);
    m_req  = !rst && (n_s != 0);
    m_data = '0;
    if (m_req) m_data = pol ? exp_q1[0] : exp_q0[0];
    chk("ready_out", ready_out, m_rdy);
    chk("req_out", req_out, m_req);
    chk("data_out", data_out, m_data);
    chk("vc0_cnt", vc0_cnt, n0);
    chk("vc1_cnt", vc1_cnt, n1);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      m_ovf = 0;
    end else begin
      if (snd && m_rdy) begin
        if (pol) exp_q0.push_back(din);
        else     exp_q1.push_back(din);
      end else if (snd && (m_ovf < 255)) begin
        m_ovf++;
      end
      if (m_req && gnt) begin
        if (pol) void'(exp_q1.pop_front());
        else     void'(exp_q0.pop_front());
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    polarity = 1'b1;
    send_in  = 1'b0;
    data_in  = '0;
    grant_in = 1'b0;
    @(posedge clk);

    // Reset, single push/pop, then fill-and-drop on VC0.
    tbl[0]  = mk(1, 1, 0, 64'h0,  0, 0, 0, 64'h0,  0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 64'h99, 0, 0, 0, 64'h0,  0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 64'hA5, 0, 1, 0, 64'h0,  0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 64'h0,  1, 1, 1, 64'hA5, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 64'h0,  0, 1, 0, 64'h0,  0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 64'h11, 0, 1, 0, 64'h0,  0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 64'h22, 0, 1, 0, 64'h0,  1, 0, 0);
    tbl[7]  = mk(0, 1, 1, 64'h33, 0, 0, 0, 64'h0,  2, 0, 0);
    tbl[8]  = mk(0, 0, 0, 64'h0,  1, 1, 1, 64'h11, 2, 0, 1);
    tbl[9]  = mk(0, 0, 0, 64'h0,  1, 1, 1, 64'h22, 1, 0, 1);
    tbl[10] = mk(0, 0, 0, 64'h0,  1, 1, 0, 64'h0,  0, 0, 1);
    tbl[11] = mk(0, 1, 0, 64'h0,  1, 1, 0, 64'h0,  0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].rst, tbl[i].pol, tbl[i].snd, tbl[i].din, tbl[i].gnt);
      chk($sformatf("tbl%0d_ready", i), ready_out, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_req", i),   req_out,   tbl[i].e_req);
      chk($sformatf("tbl%0d_data", i),  data_out,  tbl[i].e_data);
      chk($sformatf("tbl%0d_vc0", i),   vc0_cnt,   tbl[i].e_c0);
      chk($sformatf("tbl%0d_vc1", i),   vc1_cnt,   tbl[i].e_c1);
      chk($sformatf("tbl%0d_ovf", i),   ovf_cnt,   tbl[i].e_ovf);
    end

    // Streaming with polarity toggling every cycle.
    apply(1, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      apply(0, (k % 2) == 0, 1, 64'(k + 1), 1);
      chk("stream_vc0_le1", vc0_cnt <= 2'd1, 1);
      chk("stream_vc1_le1", vc1_cnt <= 2'd1, 1);
    end
    for (int k = 0; k < 3; k++) apply(0, (k % 2) == 0, 0, 0, 1);
    chk("stream_no_drop", ovf_cnt, 0);

    // Reset with flits queued in both VCs; no stale data afterwards.
    apply(0, 1, 1, 64'hAAA1, 0);
    apply(0, 1, 1, 64'hAAA2, 0);
    apply(0, 0, 1, 64'hBBB1, 0);
    apply(1, 1, 0, 0, 0);
    apply(0, 1, 1, 64'hC0DE, 0);
    chk("midrst_req", req_out, 0);
    apply(0, 0, 0, 0, 1);
    chk("midrst_fresh", data_out, 64'hC0DE);
    apply(0, 1, 0, 0, 1);
    apply(0, 0, 0, 0, 1);

    // Overflow counter saturation: fill VC0 then keep sending.
    apply(1, 1, 0, 0, 0);
    for (int k = 0; k < 302; k++) apply(0, 1, 1, 64'(k), 0);
    apply(0, 1, 0, 0, 0);
    chk("ovf_sat", ovf_cnt, 255);

    // Pointer wrap over several push/pop rounds in both VCs.
    apply(1, 1, 0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      apply(0, 1, 1, {$urandom, $urandom}, 0);
      apply(0, 0, 1, {$urandom, $urandom}, 1);
      apply(0, 1, 0, 0, 1);
    end
    apply(0, 0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 300; k++) begin
      apply($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
